// File: rtl/input_stream_feeder.sv
// -----------------------------------------------------------------------------
// input_stream_feeder
//
// Buffers a vector of VECTOR_LENGTH elements loaded one per handshake, then on
// start streams the buffered vector out one element per cycle, in index order,
// into the first cell of a weight-compare chain.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_valid     load_data carries a valid element this cycle
//   load_data      next vector element, loaded in index order
//   load_ready     feeder accepts an element this cycle (EMPTY / LOADING)
//   start          request to stream the buffered vector (honoured in FULL)
//   busy           high while output_enable is high
//   done           one-cycle pulse after the last element was presented
//   output_index   zero-extended element index
//   output_value   element value
//   output_result  chain seed, constant zero
//   output_enable  output_index / output_value valid
// -----------------------------------------------------------------------------
module input_stream_feeder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned VECTOR_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic [DATA_WIDTH:0]   output_result,
    output logic                  output_enable
);

    localparam int unsigned IdxW = $clog2(VECTOR_LENGTH);
    // load_count must be able to hold VECTOR_LENGTH itself.
    localparam int unsigned CntW = $clog2(VECTOR_LENGTH + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(VECTOR_LENGTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(VECTOR_LENGTH);

    typedef enum logic [1:0] {
        StEmpty,
        StLoading,
        StFull,
        StStream
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;

    // Vector storage; deliberately not reset, every slot is rewritten before it
    // can be streamed.
    logic [DATA_WIDTH-1:0] buffer_q [VECTOR_LENGTH];

    logic            xfer;
    logic            last_load;
    logic            stream_last;
    logic [IdxW-1:0] idx_inc;
    logic [CntW-1:0] cnt_inc;

    assign xfer        = load_valid & load_ready;
    assign cnt_inc     = cnt_q + CntW'(1);
    assign last_load   = (cnt_inc == FullCnt);
    assign idx_inc     = idx_q + IdxW'(1);
    assign stream_last = (idx_q == LastIdx);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                // VECTOR_LENGTH >= 2, so a single transfer never fills the buffer.
                if (xfer) begin
                    state_d = StLoading;
                end
            end
            StLoading: begin
                if (xfer && last_load) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (start) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (stream_last) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state only
    // -------------------------------------------------------------------------
    always_comb begin
        load_ready = 1'b0;
        unique case (state_q)
            StEmpty, StLoading: load_ready = 1'b1;
            default:            load_ready = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        val_d  = val_q;
        en_d   = en_q;
        done_d = 1'b0;

        if (xfer) begin
            cnt_d = cnt_inc;
        end

        if (state_q == StFull && start) begin
            en_d  = 1'b1;
            idx_d = '0;
            val_d = buffer_q[0];
        end else if (state_q == StStream) begin
            if (stream_last) begin
                // Index and value hold their last values while disabled.
                en_d   = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                idx_d = idx_inc;
                val_d = buffer_q[idx_inc];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    // A transfer only happens while cnt_q < VECTOR_LENGTH, so the low bits
    // address the slot directly.
    always_ff @(posedge clk) begin
        if (xfer) begin
            buffer_q[cnt_q[IdxW-1:0]] <= load_data;
        end
    end

    assign output_index  = DATA_WIDTH'(idx_q);
    assign output_value  = val_q;
    assign output_enable = en_q;
    assign busy          = en_q;
    assign done          = done_q;
    assign output_result = '0;

endmodule

// File: tb/tb_input_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_input_stream_feeder
//
// Directed and randomised load/stream sequences for input_stream_feeder. The
// reference model is the list of values the bench has loaded (model_buf): a
// stream must present model_buf[k] with index k on the k-th cycle after start.
// -----------------------------------------------------------------------------
module tb_input_stream_feeder;

    localparam int DW = 32;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          load_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] output_index;
    logic [DW-1:0] output_value;
    logic [DW:0]   output_result;
    logic          output_enable;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_buf [VL];

    input_stream_feeder #(
        .DATA_WIDTH    (DW),
        .VECTOR_LENGTH (VL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .output_index  (output_index),
        .output_value  (output_value),
        .output_result (output_result),
        .output_enable (output_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load model_buf[first..last]; mode 0 = continuous valid, 1 = valid every
    // other cycle, 2 = random valid. Idle cycles carry garbage data.
    task automatic load_range(input int first, input int last, input int mode);
        int  n      = first;
        int  budget = 0;
        int  phase  = 0;
        bit  v;
        while (n <= last && budget < 64) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (phase % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            phase++;
            load_valid = v;
            load_data  = v ? model_buf[n] : DW'($urandom);
            check("load_ready", 64'(load_ready), 64'd1);
            step();
            if (v) n++;
            check("load_no_done", 64'(done), 64'd0);
            check("load_no_en", 64'(output_enable), 64'd0);
            budget++;
        end
        load_valid = 1'b0;
        check("load_budget", 64'(n), 64'(last + 1));
    endtask

    // Start from FULL and check the whole stream; returns in the done cycle.
    task automatic stream(input bit hold_valid, input bit hold_start);
        check("pre_en", 64'(output_enable), 64'd0);
        check("ready_full", 64'(load_ready), 64'd0);
        start = 1'b1;
        if (hold_valid) begin
            load_valid = 1'b1;
            load_data  = DW'(9);
        end
        step();
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < VL; k++) begin
            check("en", 64'(output_enable), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("index", 64'(output_index), 64'(k));
            check("value", 64'(output_value), 64'(model_buf[k]));
            check("done_mid", 64'(done), 64'd0);
            check("ready_stream", 64'(load_ready), 64'd0);
            check("result", 64'(output_result), 64'd0);
            step();
        end
        check("en_off", 64'(output_enable), 64'd0);
        check("busy_off", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("ready_done", 64'(load_ready), 64'd1);
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic randomize_buf();
        for (int i = 0; i < VL; i++) model_buf[i] = DW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset values.
        #12;
        check("rst_en", 64'(output_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(load_ready), 64'd1);
        check("rst_index", 64'(output_index), 64'd0);
        check("rst_value", 64'(output_value), 64'd0);
        check("rst_result", 64'(output_result), 64'd0);
        rst_n = 1'b1;
        step();

        // start in EMPTY is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("empty_start_en", 64'(output_enable), 64'd0);
        check("empty_start_ready", 64'(load_ready), 64'd1);

        // All-ones vector.
        for (int i = 0; i < VL; i++) model_buf[i] = DW'(1);
        load_range(0, VL - 1, 0);
        check("ones_full", 64'(load_ready), 64'd0);
        stream(1'b0, 1'b0);
        step();
        check("ones_done_clear", 64'(done), 64'd0);

        // Toggling load_valid, then idle in FULL with valid high.
        for (int i = 0; i < VL; i++) model_buf[i] = DW'(5 + i);
        load_range(0, VL - 1, 1);
        check("toggle_full", 64'(load_ready), 64'd0);
        load_valid = 1'b1;
        load_data  = DW'($urandom);
        step();
        step();
        check("full_hold_ready", 64'(load_ready), 64'd0);
        check("full_hold_en", 64'(output_enable), 64'd0);
        load_valid = 1'b0;
        stream(1'b0, 1'b0);
        step();

        // start during LOADING is ignored.
        for (int i = 0; i < VL; i++) model_buf[i] = DW'(1 + i);
        load_range(0, 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("loading_start_en", 64'(output_enable), 64'd0);
        check("loading_start_ready", 64'(load_ready), 64'd1);
        step();
        check("loading_start_en2", 64'(output_enable), 64'd0);
        load_range(2, VL - 1, 0);
        stream(1'b0, 1'b0);
        step();

        // load_valid (data 9) and start held through STREAM; next vector
        // loaded from the done cycle must land at buffer[0].
        randomize_buf();
        load_range(0, VL - 1, 2);
        stream(1'b1, 1'b1);
        randomize_buf();
        load_range(0, VL - 1, 0);
        stream(1'b0, 1'b0);
        step();

        // Back-to-back vectors (1,2,3,4) then (4,3,2,1).
        for (int i = 0; i < VL; i++) model_buf[i] = DW'(1 + i);
        load_range(0, VL - 1, 0);
        stream(1'b0, 1'b0);
        for (int i = 0; i < VL; i++) model_buf[i] = DW'(VL - i);
        load_range(0, VL - 1, 0);
        check("b2b_full", 64'(load_ready), 64'd0);
        stream(1'b0, 1'b0);
        step();
        check("b2b_done_clear", 64'(done), 64'd0);

        // Reset mid-stream, after index 1 is presented.
        randomize_buf();
        load_range(0, VL - 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("abort_idx0", 64'(output_index), 64'd0);
        step();
        check("abort_idx1", 64'(output_index), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_en", 64'(output_enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(load_ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_index", 64'(output_index), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_after_done", 64'(done), 64'd0);
        check("abort_after_en", 64'(output_enable), 64'd0);
        check("abort_after_ready", 64'(load_ready), 64'd1);

        // Reset mid-load discards the partial vector.
        randomize_buf();
        load_range(0, 1, 0);
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        randomize_buf();
        load_range(0, VL - 1, 0);
        check("reload_full", 64'(load_ready), 64'd0);
        stream(1'b0, 1'b0);
        step();

        // Randomised vectors, gaps and back-to-back choices.
        for (int r = 0; r < 6; r++) begin
            randomize_buf();
            load_range(0, VL - 1, 2);
            for (int w = $urandom_range(0, 3); w > 0; w--) step();
            stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                step();
                check("rand_done_clear", 64'(done), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_stream_feeder.md
INPUT_STREAM_FEEDER -- requirements
Module: input_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of index, value and load data.
REQ-002 SHALL have parameter VECTOR_LENGTH, default 4, number of vector elements buffered and streamed (range 2..256).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_valid  input  1  load_data holds a valid element this cycle.
REQ-006 SHALL have port load_data  input  DATA_WIDTH  next vector element, loaded in index order.
REQ-007 SHALL have port load_ready  output  1  feeder accepts an element this cycle.
REQ-008 SHALL have port start  input  1  request to stream the buffered vector.
REQ-009 SHALL have port busy  output  1  high while streaming.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last element is emitted.
REQ-011 SHALL have port output_index  output  DATA_WIDTH  element index, drives first weight_comp_cell input_index.
REQ-012 SHALL have port output_value  output  DATA_WIDTH  element value, drives input_value.
REQ-013 SHALL have port output_result  output  DATA_WIDTH+1  chain seed, drives input_result; constant {1'b0, 0}.
REQ-014 SHALL have port output_enable  output  1  output_index/output_value valid, drives input_enable.

Function
REQ-015 SHALL implement FSM states EMPTY, LOADING, FULL, STREAM.
REQ-016 SHALL transfer a load element on a rising edge where load_valid and load_ready are both high, writing buffer[load_count] and incrementing load_count.
REQ-017 SHALL drive load_ready high in EMPTY and LOADING and low in FULL and STREAM (combinational from state only, not from load_valid).
REQ-018 SHALL move EMPTY->LOADING on the first transfer and to FULL on the transfer making load_count equal VECTOR_LENGTH (EMPTY->FULL is impossible since VECTOR_LENGTH>=2).
REQ-019 SHALL ignore start in EMPTY, LOADING and STREAM: no state change, no error.
REQ-020 SHALL move FULL->STREAM on a rising edge with start high; output_enable rises on that same edge with output_index=0 and output_value=buffer[0] (latency 1 cycle from start sampled).
REQ-021 SHALL, in STREAM, emit one element per cycle with no gaps: index k in the k-th cycle after the start edge, k=0..VECTOR_LENGTH-1, and output_value=buffer[k].
REQ-022 SHALL register output_index, output_value and output_enable (no combinational path from inputs).
REQ-023 SHALL, on the edge after index VECTOR_LENGTH-1 was presented, drop output_enable, pulse done high for exactly one cycle, clear load_count and return to EMPTY.
REQ-024 SHALL keep busy high exactly during cycles where output_enable is high.
REQ-025 SHALL hold output_index and output_value at their last values while output_enable is low (not required to be meaningful).
REQ-026 SHALL zero-extend the internal index counter (ceil(log2(VECTOR_LENGTH)) bits) to DATA_WIDTH on output_index.
REQ-027 SHALL accept a load transfer in the same cycle the done pulse is high, since the state is already EMPTY (back-to-back vectors).
REQ-028 SHALL drive output_result as constant {1'b0, DATA_WIDTH'b0} in all states.

Reset
REQ-029 SHALL, while rst_n is low, force state EMPTY, load_count 0, output_enable 0, output_index 0, output_value 0, busy 0, done 0, load_ready 1.
REQ-030 SHALL abort any load or stream on rst_n assertion mid-operation; a partially loaded or partially streamed vector is discarded and not resumed.
REQ-031 SHALL leave buffer contents unreset; they are unobservable until rewritten.

Verification
REQ-032 SHALL pass: load 1,1,1,1 then start -> indices 0,1,2,3 with value 1 on four consecutive cycles, then done; through the two-layer integration chain argmax reports index 3 (layer-2 ReLU values 97,124,41,164).
REQ-033 SHALL pass: load 5,6,7,8 with load_valid toggling every other cycle -> exactly 4 transfers, load_ready low after the 4th; start -> values 5,6,7,8.
REQ-034 SHALL pass: start pulsed after 2 of 4 loads -> no output_enable; complete loads of 3,4; start -> values per load order, first element first.
REQ-035 SHALL pass: load_valid held high during STREAM with data 9 -> no transfer, buffer unchanged; after done, next load is written to buffer[0].
REQ-036 SHALL pass: rst_n low during stream after index 1 -> output_enable 0 immediately (asynchronous), state EMPTY, load_ready 1, no done pulse.
REQ-037 SHALL pass: two vectors (1,2,3,4) and (4,3,2,1) loaded back-to-back starting in the done cycle -> second stream correct, no element from the first vector repeated.
